// File: rtl/timer_counter_request.sv
// Counter-increment request arbiter: edge-detects scaler phases into a pending mask
// and grants one counter per memory cycle, lowest index first, on the T12 boundary.
module timer_counter_request (
  input  logic       SIM_CLK,
  input  logic       SIM_RST_,
  input  logic       T12,
  input  logic       F10A,
  input  logic       F10B,
  input  logic       F09A,
  input  logic       F09B,
  input  logic       OVFIN,
  input  logic       INCINH,
  output logic       INKL,
  output logic [2:0] CTRSEL,
  output logic [4:0] PEND,
  output logic       LOST
);

  typedef enum logic [1:0] {IDLE, ARMED, CYCLE} state_t;

  state_t     state;
  logic [3:0] f_in, f_hist, f_edge;
  logic [4:0] req_set, grant_oh, grant_clr, pend_nxt;
  logic [2:0] grant_code;
  logic       grant, lost_nxt;

  assign f_in   = {F09B, F09A, F10B, F10A};
  assign f_edge = f_in & ~f_hist;

  // OVFIN is a level carry, only meaningful while TIME1 owns the cycle.
  assign req_set = {OVFIN && (state == CYCLE) && (CTRSEL == 3'd2), f_edge};

  // Lowest pending index wins: scan downward so the last hit is the lowest bit.
  always_comb begin
    grant_oh   = '0;
    grant_code = '0;
    for (int i = 4; i >= 0; i--) begin
      if (PEND[i]) begin
        grant_oh   = 5'(1) << i;
        grant_code = 3'(i + 1);
      end
    end
  end

  assign grant     = T12 && !INCINH && (PEND != '0) && (state != IDLE);
  assign grant_clr = grant ? grant_oh : '0;
  // A new request on the bit being granted survives: set beats clear.
  assign pend_nxt  = (PEND & ~grant_clr) | req_set;
  assign lost_nxt  = |(f_edge & PEND[3:0] & ~grant_clr[3:0]);

  always_ff @(posedge SIM_CLK or negedge SIM_RST_) begin
    if (!SIM_RST_) begin
      state  <= IDLE;
      f_hist <= '1;
      PEND   <= '0;
      LOST   <= 1'b0;
      INKL   <= 1'b0;
      CTRSEL <= '0;
    end else begin
      f_hist <= f_in;
      PEND   <= pend_nxt;
      LOST   <= lost_nxt;
      case (state)
        IDLE: begin
          if (pend_nxt != '0) state <= ARMED;
        end
        ARMED: begin
          if (grant) begin
            INKL   <= 1'b1;
            CTRSEL <= grant_code;
            state  <= CYCLE;
          end
        end
        CYCLE: begin
          if (T12) begin
            if (grant) begin
              CTRSEL <= grant_code;
            end else begin
              INKL   <= 1'b0;
              CTRSEL <= '0;
              state  <= (pend_nxt != '0) ? ARMED : IDLE;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_timer_counter_request.sv
// Directed bench for timer_counter_request: a vector table for the main grant flow
// plus hand sequences for inhibit, collisions and mid-cycle reset.
module tb_timer_counter_request;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       t12, ovf, inh;
  logic [3:0] f;
  logic       inkl, lost;
  logic [2:0] ctrsel;
  logic [4:0] pend;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  timer_counter_request dut (
    .SIM_CLK (clk),
    .SIM_RST_(rst_n),
    .T12     (t12),
    .F10A    (f[0]),
    .F10B    (f[1]),
    .F09A    (f[2]),
    .F09B    (f[3]),
    .OVFIN   (ovf),
    .INCINH  (inh),
    .INKL    (inkl),
    .CTRSEL  (ctrsel),
    .PEND    (pend),
    .LOST    (lost)
  );

  typedef struct {
    logic [3:0] f;
    logic       t12, ovf, inh;
    logic       inkl;
    logic [2:0] ct;
    logic [4:0] pend;
    logic       lost;
  } vec_t;

  vec_t tbl[22];

  function automatic vec_t mk(logic [3:0] fi, logic ti, logic oi, logic ii,
                              logic ek, logic [2:0] ec, logic [4:0] ep, logic el);
    vec_t v;
    v.f = fi; v.t12 = ti; v.ovf = oi; v.inh = ii;
    v.inkl = ek; v.ct = ec; v.pend = ep; v.lost = el;
    return v;
  endfunction

  task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic check_all(input string tag, input logic ek, input logic [2:0] ec,
                           input logic [4:0] ep, input logic el);
    check({tag, ".inkl"},   {7'd0, inkl}, {7'd0, ek});
    check({tag, ".ctrsel"}, {5'd0, ctrsel}, {5'd0, ec});
    check({tag, ".pend"},   {3'd0, pend}, {3'd0, ep});
    check({tag, ".lost"},   {7'd0, lost}, {7'd0, el});
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    //                f        t12   ovf   inh   inkl  ct    pend      lost
    // single request: F10B, T12 three cycles after the edge
    tbl[0]  = mk(4'b0010, 1'b0, 1'b0, 1'b0, 1'b0, 3'd0, 5'b00010, 1'b0);
    tbl[1]  = mk(4'b0010, 1'b0, 1'b0, 1'b0, 1'b0, 3'd0, 5'b00010, 1'b0);
    tbl[2]  = mk(4'b0010, 1'b0, 1'b0, 1'b0, 1'b0, 3'd0, 5'b00010, 1'b0);
    tbl[3]  = mk(4'b0010, 1'b1, 1'b0, 1'b0, 1'b1, 3'd2, 5'b00000, 1'b0);
    tbl[4]  = mk(4'b0010, 1'b0, 1'b0, 1'b0, 1'b1, 3'd2, 5'b00000, 1'b0);
    tbl[5]  = mk(4'b0000, 1'b1, 1'b0, 1'b0, 1'b0, 3'd0, 5'b00000, 1'b0);
    // priority: TIME3 then TIME4 back-to-back
    tbl[6]  = mk(4'b1001, 1'b0, 1'b0, 1'b0, 1'b0, 3'd0, 5'b01001, 1'b0);
    tbl[7]  = mk(4'b1001, 1'b1, 1'b0, 1'b0, 1'b1, 3'd1, 5'b01000, 1'b0);
    tbl[8]  = mk(4'b0000, 1'b0, 1'b0, 1'b0, 1'b1, 3'd1, 5'b01000, 1'b0);
    tbl[9]  = mk(4'b0000, 1'b1, 1'b0, 1'b0, 1'b1, 3'd4, 5'b00000, 1'b0);
    tbl[10] = mk(4'b0000, 1'b0, 1'b0, 1'b0, 1'b1, 3'd4, 5'b00000, 1'b0);
    tbl[11] = mk(4'b0000, 1'b1, 1'b0, 1'b0, 1'b0, 3'd0, 5'b00000, 1'b0);
    // carry from TIME1 into TIME2
    tbl[12] = mk(4'b0010, 1'b0, 1'b0, 1'b0, 1'b0, 3'd0, 5'b00010, 1'b0);
    tbl[13] = mk(4'b0000, 1'b1, 1'b0, 1'b0, 1'b1, 3'd2, 5'b00000, 1'b0);
    tbl[14] = mk(4'b0000, 1'b0, 1'b1, 1'b0, 1'b1, 3'd2, 5'b10000, 1'b0);
    tbl[15] = mk(4'b0000, 1'b0, 1'b0, 1'b0, 1'b1, 3'd2, 5'b10000, 1'b0);
    tbl[16] = mk(4'b0000, 1'b1, 1'b0, 1'b0, 1'b1, 3'd5, 5'b00000, 1'b0);
    tbl[17] = mk(4'b0000, 1'b1, 1'b0, 1'b0, 1'b0, 3'd0, 5'b00000, 1'b0);
    // OVFIN outside a TIME1 cycle is ignored
    tbl[18] = mk(4'b0000, 1'b0, 1'b1, 1'b0, 1'b0, 3'd0, 5'b00000, 1'b0);
    // T12 on the edge cycle does not grant; the next T12 does
    tbl[19] = mk(4'b0001, 1'b1, 1'b0, 1'b0, 1'b0, 3'd0, 5'b00001, 1'b0);
    tbl[20] = mk(4'b0001, 1'b1, 1'b0, 1'b0, 1'b1, 3'd1, 5'b00000, 1'b0);
    tbl[21] = mk(4'b0000, 1'b1, 1'b0, 1'b0, 1'b0, 3'd0, 5'b00000, 1'b0);

    rst_n = 1'b0; t12 = 1'b0; ovf = 1'b0; inh = 1'b0; f = 4'b0000;
    #12;
    check_all("reset", 1'b0, 3'd0, 5'b00000, 1'b0);
    tick();
    rst_n = 1'b1;
    tick();
    tick();
    check_all("idle", 1'b0, 3'd0, 5'b00000, 1'b0);

    for (int i = 0; i < 22; i++) begin
      f = tbl[i].f; t12 = tbl[i].t12; ovf = tbl[i].ovf; inh = tbl[i].inh;
      tick();
      check_all($sformatf("vec%0d", i), tbl[i].inkl, tbl[i].ct, tbl[i].pend, tbl[i].lost);
    end
    f = 4'b0000; t12 = 1'b0; ovf = 1'b0; inh = 1'b0;
    tick();

    // inhibit holds a pending TIME5 across two T12s
    f = 4'b0100; tick();
    check_all("inh_req", 1'b0, 3'd0, 5'b00100, 1'b0);
    f = 4'b0000; inh = 1'b1; t12 = 1'b1; tick();
    check_all("inh_t12a", 1'b0, 3'd0, 5'b00100, 1'b0);
    t12 = 1'b0; tick();
    t12 = 1'b1; tick();
    check_all("inh_t12b", 1'b0, 3'd0, 5'b00100, 1'b0);
    inh = 1'b0; t12 = 1'b0; tick();
    check_all("inh_drop", 1'b0, 3'd0, 5'b00100, 1'b0);
    t12 = 1'b1; tick();
    check_all("inh_grant", 1'b1, 3'd3, 5'b00000, 1'b0);
    tick();
    check_all("inh_end", 1'b0, 3'd0, 5'b00000, 1'b0);
    t12 = 1'b0;

    // second edge on an already pending bit pulses LOST once
    f = 4'b0100; tick();
    check_all("lost_req", 1'b0, 3'd0, 5'b00100, 1'b0);
    f = 4'b0000; tick();
    f = 4'b0100; tick();
    check_all("lost_pulse", 1'b0, 3'd0, 5'b00100, 1'b1);
    tick();
    check_all("lost_clear", 1'b0, 3'd0, 5'b00100, 1'b0);
    f = 4'b0000; tick();
    // edge coinciding with the grant of the same bit keeps it pending
    f = 4'b0100; t12 = 1'b1; tick();
    check_all("coll_grant", 1'b1, 3'd3, 5'b00100, 1'b0);
    f = 4'b0000; tick();
    check_all("coll_again", 1'b1, 3'd3, 5'b00000, 1'b0);
    tick();
    check_all("coll_end", 1'b0, 3'd0, 5'b00000, 1'b0);
    t12 = 1'b0;

    // reset during a TIME1 cycle with carry asserted
    f = 4'b0010; tick();
    t12 = 1'b1; tick();
    check_all("rst_pre", 1'b1, 3'd2, 5'b00000, 1'b0);
    t12 = 1'b0; ovf = 1'b1; f = 4'b1111;
    #2 rst_n = 1'b0;
    #1;
    check_all("rst_abort", 1'b0, 3'd0, 5'b00000, 1'b0);
    tick();
    tick();
    rst_n = 1'b1; ovf = 1'b0;
    tick();
    tick();
    check_all("rst_held_hi", 1'b0, 3'd0, 5'b00000, 1'b0);
    f = 4'b0000; tick();
    f = 4'b0001; tick();
    check_all("rst_new_edge", 1'b0, 3'd0, 5'b00001, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #20000;
    $display("FAIL timeout: simulation exceeded time budget");
    $fatal(1, "timeout");
  end

endmodule
